// File: rtl/memory_writer.sv
// memory_writer: capture buffer for the monopulse relation stream.
// An i_start pulse arms a record of DEPTH consecutive valid samples. Once the
// record is full, further writes are blocked until the next i_start.
// A one-cycle-latency read port lets the host drain the record in any state.
module memory_writer #(
    parameter  int DATA_SIZE = 64,
    parameter  int DEPTH     = 1024,
    localparam int ADDR_SIZE = $clog2(DEPTH)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [DATA_SIZE-1:0] i_data,
    input  logic                 i_valid,
    input  logic                 i_start,
    input  logic                 i_rd_en,
    input  logic [ADDR_SIZE-1:0] i_rd_addr,
    output logic [DATA_SIZE-1:0] o_rd_data,
    output logic                 o_rd_valid,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ADDR_SIZE:0]   o_count,
    output logic                 o_overflow
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    localparam logic [ADDR_SIZE:0] LAST_SLOT = (ADDR_SIZE + 1)'(DEPTH - 1);

    logic [1:0]           state_q, state_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 busy_q, done_q;
    logic                 wr_en;

    logic [DATA_SIZE-1:0] mem [DEPTH];
    logic [DATA_SIZE-1:0] ram_rd_q;
    logic                 rd_valid_q;
    logic                 rd_show_q;
    logic                 rd_in_range;

    // A slot counts as captured only once it has been written in the current record.
    assign rd_in_range = ({1'b0, i_rd_addr} < count_q);

    // Next-state logic: arm, count valid samples, detect full, flag overflow.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Samples arriving alongside the start pulse are not captured.
                if (i_start) begin
                    state_d = ST_CAPTURE;
                    count_d = '0;
                end
            end
            ST_CAPTURE: begin
                // i_start is deliberately ignored here: no restart mid-record.
                if (i_valid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + 1'b1;
                    if (count_q == LAST_SLOT) begin
                        state_d = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (i_start) begin
                    state_d    = ST_CAPTURE;
                    count_d    = '0;
                    overflow_d = 1'b0;
                end else if (i_valid) begin
                    overflow_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers; busy/done are registered from the next state so they align with it.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            busy_q     <= (state_d == ST_CAPTURE);
            done_q     <= (state_d == ST_FULL);
        end
    end

    // Sample storage write port; the address is the count truncated to slot width.
    always_ff @(posedge i_clock) begin
        if (wr_en) begin
            mem[count_q[ADDR_SIZE-1:0]] <= i_data;
        end
    end

    // Registered read without reset so it maps onto the RAM output register (read-first).
    always_ff @(posedge i_clock) begin
        if (i_rd_en) begin
            ram_rd_q <= mem[i_rd_addr];
        end
    end

    // Read qualifiers: valid pulses per request, show mask holds with the data between requests.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rd_valid_q <= 1'b0;
            rd_show_q  <= 1'b0;
        end else begin
            rd_valid_q <= i_rd_en & rd_in_range;
            if (i_rd_en) begin
                rd_show_q <= rd_in_range;
            end
        end
    end

    // Uncaptured slots read back as zero, so stale RAM contents never leak out.
    assign o_rd_data  = rd_show_q ? ram_rd_q : '0;
    assign o_rd_valid = rd_valid_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_count    = count_q;
    assign o_overflow = overflow_q;

endmodule

// File: tb/tb_memory_writer.sv
// Bench for memory_writer with DEPTH=8, DATA_SIZE=64: a behavioural model of
// the capture record, a per-cycle compare against it, and literal checks.
module tb_memory_writer;

    localparam int DW    = 64;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] data;
    logic          valid;
    logic          start;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    memory_writer #(.DATA_SIZE(DW), .DEPTH(DEPTH)) dut (
        .i_clock   (clk),
        .i_reset   (rst_n),
        .i_data    (data),
        .i_valid   (valid),
        .i_start   (start),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_addr),
        .o_rd_data (rd_data),
        .o_rd_valid(rd_valid),
        .o_busy    (busy),
        .o_done    (done),
        .o_count   (count),
        .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Record phase: 0 = not armed, 1 = recording, 2 = record complete.
    int            m_phase;
    int            m_count;
    bit            m_over;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rd_data;
    bit            m_rd_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase    <= 0;
            m_count    <= 0;
            m_over     <= 1'b0;
            m_rd_data  <= '0;
            m_rd_valid <= 1'b0;
        end else begin
            if (rd_en) begin
                if (int'(rd_addr) < m_count) begin
                    m_rd_valid <= 1'b1;
                    m_rd_data  <= m_mem[rd_addr];
                end else begin
                    m_rd_valid <= 1'b0;
                    m_rd_data  <= '0;
                end
            end else begin
                m_rd_valid <= 1'b0;
            end
            if (m_phase == 1) begin
                if (valid) begin
                    m_mem[m_count] <= data;
                    m_count        <= m_count + 1;
                    if (m_count + 1 == DEPTH) m_phase <= 2;
                end
            end else if (start) begin
                m_phase <= 1;
                m_count <= 0;
                m_over  <= 1'b0;
            end else if (m_phase == 2 && valid) begin
                m_over <= 1'b1;
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        chk("cyc_busy",     64'(busy),     64'(m_phase == 1));
        chk("cyc_done",     64'(done),     64'(m_phase == 2));
        chk("cyc_count",    64'(count),    64'(m_count));
        chk("cyc_overflow", 64'(overflow), 64'(m_over));
        chk("cyc_rd_valid", 64'(rd_valid), 64'(m_rd_valid));
        chk("cyc_rd_data",  rd_data,       m_rd_data);
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [DW-1:0] d, input logic s,
                        input logic re, input logic [AW-1:0] ra);
        valid   = v;
        data    = d;
        start   = s;
        rd_en   = re;
        rd_addr = ra;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step(1'b0, '0, 1'b0, 1'b1, a);
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0; data = '0; start = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state and a read of an uncaptured slot.
        rd(3'd0);
        $display("txn reset-read addr0 valid=%0d data=%0h", rd_valid, rd_data);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data",  rd_data, 64'd0);
        chk("rst_count",    64'(count), 64'd0);
        chk("rst_busy",     64'(busy), 64'd0);
        chk("rst_done",     64'(done), 64'd0);

        // Full record 0x10..0x17.
        step(1'b0, '0, 1'b1, 1'b0, '0);
        chk("arm_busy", 64'(busy), 64'd1);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 64'h10 + 64'(i), 1'b0, 1'b0, '0);
            $display("txn write 0x%0h count=%0d", 64'h10 + 64'(i), count);
        end
        chk("fill_done",  64'(done), 64'd1);
        chk("fill_count", 64'(count), 64'd8);
        chk("fill_busy",  64'(busy), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rd(AW'(i));
            $display("txn read addr%0d valid=%0d data=%0h", i, rd_valid, rd_data);
            chk("fill_rd_valid", 64'(rd_valid), 64'd1);
            chk("fill_rd_data",  rd_data, 64'h10 + 64'(i));
        end
        idle();
        chk("hold_rd_data",  rd_data, 64'h17);
        chk("hold_rd_valid", 64'(rd_valid), 64'd0);

        // Start with a coincident sample that must not be stored.
        step(1'b1, 64'hAA, 1'b1, 1'b0, '0);
        step(1'b1, 64'h01, 1'b0, 1'b0, '0);
        step(1'b1, 64'h02, 1'b0, 1'b0, '0);
        chk("skip_count", 64'(count), 64'd2);
        rd(3'd0);
        $display("txn read addr0 valid=%0d data=%0h", rd_valid, rd_data);
        chk("skip_addr0", rd_data, 64'h01);
        rd(3'd1);
        chk("skip_addr1", rd_data, 64'h02);
        rd(3'd2);
        chk("skip_addr2_valid", 64'(rd_valid), 64'd0);

        // Fill to complete, then overflow.
        for (int i = 0; i < 6; i++) step(1'b1, 64'h30 + 64'(i), 1'b0, 1'b0, '0);
        chk("refill_done", 64'(done), 64'd1);
        step(1'b1, 64'hFF, 1'b0, 1'b0, '0);
        $display("txn overflow write 0xff overflow=%0d count=%0d", overflow, count);
        chk("ovf_flag",  64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd8);
        rd(3'd7);
        chk("ovf_addr7", rd_data, 64'h35);
        idle();
        chk("ovf_sticky", 64'(overflow), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0, '0);
        chk("restart_ovf",   64'(overflow), 64'd0);
        chk("restart_done",  64'(done), 64'd0);
        chk("restart_count", 64'(count), 64'd0);

        // Gapped samples, start ignored mid-record, read-first collision on slot 0.
        step(1'b1, 64'h5, 1'b0, 1'b1, 3'd0);
        chk("collide_valid", 64'(rd_valid), 64'd0);
        idle();
        step(1'b0, '0, 1'b1, 1'b0, '0);
        step(1'b1, 64'h6, 1'b0, 1'b0, '0);
        chk("gap_count", 64'(count), 64'd2);
        chk("gap_busy",  64'(busy), 64'd1);
        rd(3'd2);
        chk("gap_addr2_valid", 64'(rd_valid), 64'd0);
        rd(3'd1);
        $display("txn read addr1 valid=%0d data=%0h", rd_valid, rd_data);
        chk("gap_addr1", rd_data, 64'h6);

        // Asynchronous reset after three samples.
        step(1'b1, 64'h7, 1'b0, 1'b0, '0);
        chk("pre_rst_count", 64'(count), 64'd3);
        rst_n = 1'b0;
        #1;
        $display("txn async reset busy=%0d count=%0d", busy, count);
        chk("arst_busy",  64'(busy), 64'd0);
        chk("arst_count", 64'(count), 64'd0);
        idle();
        rst_n = 1'b1;
        rd(3'd0);
        chk("arst_rd_valid", 64'(rd_valid), 64'd0);
        idle();
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
